memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of all data buses.
REQ-002 Parameter ADDRESS_WIDTH, default 16, width of all address buses.
REQ-003 Parameter STARVE_LIMIT, default 4, number of consecutive denied display cycles before display is forced to win.
REQ-004 Port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port cpu_request, input, 1: CPU requests one memory access this cycle.
REQ-007 Port cpu_write, input, 1: 1 = store, 0 = load; meaningful only with cpu_request.
REQ-008 Port cpu_address, input, ADDRESS_WIDTH: CPU access address.
REQ-009 Port cpu_write_data, input, DATA_WIDTH: CPU store data.
REQ-010 Port cpu_grant, output, 1: CPU access is performed this cycle (combinational).
REQ-011 Port cpu_read_valid, output, 1: cpu_read_data holds the load result (registered).
REQ-012 Port cpu_read_data, output, DATA_WIDTH: CPU load result.
REQ-013 Port display_request, input, 1: display requests one read this cycle.
REQ-014 Port display_address, input, ADDRESS_WIDTH: display read address.
REQ-015 Port display_grant, output, 1: display read is performed this cycle (combinational).
REQ-016 Port display_read_valid, output, 1: display_read_data holds the read result (registered).
REQ-017 Port display_read_data, output, DATA_WIDTH: display read result.
REQ-018 Port memory_address, output, ADDRESS_WIDTH: address driven to the single-port RAM.
REQ-019 Port memory_write_data, output, DATA_WIDTH: RAM write data.
REQ-020 Port memory_write_enable, output, 1: RAM write strobe.
REQ-021 Port memory_read_data, input, DATA_WIDTH: RAM read data, valid one cycle after the address is presented.

Function
REQ-022 At most one of cpu_grant and display_grant SHALL be 1 in any cycle, and a grant SHALL be asserted only to an active requester.
REQ-023 Priority: the CPU SHALL win when both request, unless starve_count == STARVE_LIMIT, in which case the display SHALL win.
REQ-024 starve_count: increments (saturating at STARVE_LIMIT) when display_request=1 and display_grant=0; clears to 0 on display_grant or when display_request=0.
REQ-025 The memory port mux SHALL select the granted requester: memory_address = granted address; memory_write_enable = cpu_grant & cpu_write; memory_write_data = cpu_write_data.
REQ-026 With no grant: memory_address = 0 and memory_write_enable = 0.
REQ-027 Read latency SHALL be exactly 1 cycle. A CPU load granted in cycle N SHALL produce cpu_read_valid=1 in cycle N+1 only, with cpu_read_data = memory_read_data.
REQ-028 A display read granted in cycle N SHALL produce display_read_valid=1 in cycle N+1 only, with display_read_data = memory_read_data.
REQ-029 A CPU store SHALL NOT raise cpu_read_valid.
REQ-030 Owner tag register last_owner ∈ {NONE, CPU_READ, DISPLAY_READ} SHALL record each cycle's granted read and route the next cycle's memory_read_data.
REQ-031 read_data outputs SHALL hold their last value when valid=0.
REQ-032 A denied requester SHALL NOT be queued; it keeps its request asserted until granted.
REQ-033 Back-to-back grants (alternating or same owner) SHALL be accepted every cycle without bubbles.

Reset
REQ-034 While reset=1: both grants = 0, memory_write_enable = 0, both valids = 0, starve_count = 0, last_owner = NONE, read_data outputs = 0.
REQ-035 Reset asserted with a read in flight SHALL suppress the valid pulse in the following cycle.
REQ-036 On the first cycle after reset deasserts, the arbiter SHALL arbitrate normally.

Verification
REQ-037 CPU load at 0x0010 only, RAM[0x0010]=0xBEEF -> cpu_grant the same cycle; next cycle cpu_read_valid=1, cpu_read_data=0xBEEF.
REQ-038 CPU store 0x1234 to 0x0020 -> memory_write_enable=1 for one cycle, cpu_read_valid stays 0; a later load of 0x0020 returns 0x1234.
REQ-039 Both request continuously, STARVE_LIMIT=4 -> CPU granted cycles 0-3, display cycle 4, CPU cycles 5-8, display cycle 9.
REQ-040 Alternating grants CPU read at 0x1 then display read at 0x2 -> valids pulse on consecutive cycles, each carrying its own data with no cross-routing.
REQ-041 reset asserted the cycle after a display grant -> display_read_valid stays 0, starve_count = 0.
REQ-042 Display alone requesting for 10 cycles -> granted every cycle, starve_count stays 0.

Source files
------------

// File: rtl/memory_arbiter.sv
// Two-requester arbiter for a single-port RAM: CPU has priority, the display is
// forced through after STARVE_LIMIT consecutive denied cycles.
module memory_arbiter #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 16,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpu_request,
    input  logic                     cpu_write,
    input  logic [ADDRESS_WIDTH-1:0] cpu_address,
    input  logic [DATA_WIDTH-1:0]    cpu_write_data,
    output logic                     cpu_grant,
    output logic                     cpu_read_valid,
    output logic [DATA_WIDTH-1:0]    cpu_read_data,
    input  logic                     display_request,
    input  logic [ADDRESS_WIDTH-1:0] display_address,
    output logic                     display_grant,
    output logic                     display_read_valid,
    output logic [DATA_WIDTH-1:0]    display_read_data,
    output logic [ADDRESS_WIDTH-1:0] memory_address,
    output logic [DATA_WIDTH-1:0]    memory_write_data,
    output logic                     memory_write_enable,
    input  logic [DATA_WIDTH-1:0]    memory_read_data
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        OWNER_NONE,
        OWNER_CPU_READ,
        OWNER_DISPLAY_READ
    } owner_t;

    owner_t                  last_owner;
    logic [SW-1:0]           starve_count;
    logic [DATA_WIDTH-1:0]   cpu_hold;
    logic [DATA_WIDTH-1:0]   display_hold;
    logic                    display_wins;
    logic                    starved;

    assign starved      = (starve_count == SW'(STARVE_LIMIT));
    assign display_wins = display_request && (!cpu_request || starved);

    always_comb begin
        cpu_grant           = 1'b0;
        display_grant       = 1'b0;
        memory_address      = '0;
        memory_write_enable = 1'b0;
        if (!reset) begin
            display_grant       = display_wins;
            cpu_grant           = cpu_request && !display_wins;
            memory_write_enable = cpu_grant && cpu_write;
            if (cpu_grant)
                memory_address = cpu_address;
            else if (display_grant)
                memory_address = display_address;
        end
    end

    assign memory_write_data = cpu_write_data;

    // RAM data arrives in the cycle after the grant, so results pass straight
    // through while valid and are otherwise held from the last valid cycle.
    assign cpu_read_valid     = !reset && (last_owner == OWNER_CPU_READ);
    assign display_read_valid = !reset && (last_owner == OWNER_DISPLAY_READ);

    always_comb begin
        cpu_read_data     = cpu_hold;
        display_read_data = display_hold;
        if (reset) begin
            cpu_read_data     = '0;
            display_read_data = '0;
        end else begin
            if (cpu_read_valid)
                cpu_read_data = memory_read_data;
            if (display_read_valid)
                display_read_data = memory_read_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_owner   <= OWNER_NONE;
            starve_count <= '0;
            cpu_hold     <= '0;
            display_hold <= '0;
        end else begin
            if (cpu_read_valid)
                cpu_hold <= memory_read_data;
            if (display_read_valid)
                display_hold <= memory_read_data;

            if (cpu_grant && !cpu_write)
                last_owner <= OWNER_CPU_READ;
            else if (display_grant)
                last_owner <= OWNER_DISPLAY_READ;
            else
                last_owner <= OWNER_NONE;

            if (display_request && !display_grant) begin
                if (!starved)
                    starve_count <= starve_count + SW'(1);
            end else begin
                starve_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized and directed bench for memory_arbiter against a cycle-level
// reference model with its own copy of RAM contents.
module tb_memory_arbiter;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int LIMIT = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_request = 1'b0, cpu_write = 1'b0;
    logic [AW-1:0] cpu_address = '0;
    logic [DW-1:0] cpu_write_data = '0;
    logic          cpu_grant, cpu_read_valid;
    logic [DW-1:0] cpu_read_data;
    logic          display_request = 1'b0;
    logic [AW-1:0] display_address = '0;
    logic          display_grant, display_read_valid;
    logic [DW-1:0] display_read_data;
    logic [AW-1:0] memory_address;
    logic [DW-1:0] memory_write_data;
    logic          memory_write_enable;
    logic [DW-1:0] memory_read_data = '0;

    memory_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .cpu_request(cpu_request), .cpu_write(cpu_write),
        .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
        .cpu_grant(cpu_grant), .cpu_read_valid(cpu_read_valid),
        .cpu_read_data(cpu_read_data),
        .display_request(display_request), .display_address(display_address),
        .display_grant(display_grant), .display_read_valid(display_read_valid),
        .display_read_data(display_read_data),
        .memory_address(memory_address), .memory_write_data(memory_write_data),
        .memory_write_enable(memory_write_enable), .memory_read_data(memory_read_data)
    );

    always #5 clock = ~clock;

    // Single-port synchronous RAM the arbiter drives.
    logic [DW-1:0] ram [0:65535];
    always @(posedge clock) begin
        if (memory_write_enable)
            ram[memory_address] <= memory_write_data;
        memory_read_data <= ram[memory_address];
    end

    // Reference model state
    logic [DW-1:0] ref_mem [0:65535];
    int            starve;
    bit            pend_cpu, pend_disp;
    logic [DW-1:0] pend_data, exp_cpu_data, exp_disp_data;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int a);
        return DW'((a * 40503) ^ 16'h5a5a);
    endfunction

    // One clock cycle: drive inputs, compare every observable against the model,
    // then advance the model across the coming rising edge.
    task automatic step(input bit rst, input bit creq, input bit cw,
                        input logic [AW-1:0] ca, input logic [DW-1:0] cwd,
                        input bit dreq, input logic [AW-1:0] da);
        bit            e_cg, e_dg;
        logic [AW-1:0] e_addr;
        @(negedge clock);
        reset = rst; cpu_request = creq; cpu_write = cw; cpu_address = ca;
        cpu_write_data = cwd; display_request = dreq; display_address = da;
        #1;
        e_dg = !rst && dreq && (!creq || starve == LIMIT);
        e_cg = !rst && creq && !e_dg;
        e_addr = e_cg ? ca : (e_dg ? da : '0);
        check_value("cpu_grant", cpu_grant, e_cg);
        check_value("display_grant", display_grant, e_dg);
        check_value("memory_address", memory_address, e_addr);
        check_value("memory_write_enable", memory_write_enable, e_cg && cw);
        check_value("memory_write_data", memory_write_data, cwd);

        if (rst) begin
            exp_cpu_data = '0;
            exp_disp_data = '0;
        end else begin
            if (pend_cpu)  exp_cpu_data  = pend_data;
            if (pend_disp) exp_disp_data = pend_data;
        end
        check_value("cpu_read_valid", cpu_read_valid, !rst && pend_cpu);
        check_value("display_read_valid", display_read_valid, !rst && pend_disp);
        check_value("cpu_read_data", cpu_read_data, exp_cpu_data);
        check_value("display_read_data", display_read_data, exp_disp_data);

        pend_cpu  = e_cg && !cw;
        pend_disp = e_dg;
        pend_data = ref_mem[e_addr];
        if (e_cg && cw) ref_mem[ca] = cwd;
        if (rst || !dreq || e_dg) starve = 0;
        else if (starve < LIMIT) starve++;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i]     <= init_word(i);
            ref_mem[i]  = init_word(i);
        end
        ram[16'h0010]     <= 16'hBEEF;
        ref_mem[16'h0010]  = 16'hBEEF;
        starve = 0; pend_cpu = 0; pend_disp = 0; pend_data = '0;
        exp_cpu_data = '0; exp_disp_data = '0;

        // Reset with requests pending: nothing may be granted
        step(1, 0, 0, '0, '0, 0, '0);
        step(1, 1, 1, 16'h5, 16'h1, 1, 16'h6);
        step(1, 1, 0, 16'h5, 16'h0, 1, 16'h6);

        // Load 0x0010, result next cycle
        step(0, 1, 0, 16'h0010, '0, 0, '0);
        step(0, 0, 0, '0, '0, 0, '0);
        check_value("beef_load", cpu_read_data, 16'hBEEF);

        // Store then load back
        step(0, 1, 1, 16'h0020, 16'h1234, 0, '0);
        step(0, 0, 0, '0, '0, 0, '0);
        step(0, 1, 0, 16'h0020, '0, 0, '0);
        step(0, 0, 0, '0, '0, 0, '0);
        check_value("store_readback", cpu_read_data, 16'h1234);

        // Continuous contention: display wins every fifth cycle
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, AW'(i), '0, 1, AW'(i + 100));
            check_value("starve_pattern", display_grant, (i == 4) || (i == 9));
        end
        step(0, 0, 0, '0, '0, 0, '0);

        // Alternating CPU/display reads
        step(0, 1, 0, 16'h0001, '0, 0, '0);
        step(0, 0, 0, '0, '0, 1, 16'h0002);
        step(0, 0, 0, '0, '0, 0, '0);
        step(0, 0, 0, '0, '0, 0, '0);

        // Display alone for 10 cycles
        for (int i = 0; i < 10; i++)
            step(0, 0, 0, '0, '0, 1, AW'(i + 40));
        step(0, 0, 0, '0, '0, 0, '0);

        // Reset right after a display grant, with starvation partly built up
        step(0, 1, 0, 16'h3, '0, 1, 16'h7);
        step(0, 1, 0, 16'h3, '0, 1, 16'h7);
        step(0, 0, 0, '0, '0, 1, 16'h8);
        step(1, 0, 0, '0, '0, 0, '0);
        for (int i = 0; i < 5; i++)
            step(0, 1, 0, AW'(i), '0, 1, AW'(i + 50));

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0, AW'($urandom_range(0, 15)), DW'($urandom),
                 $urandom_range(0, 2) != 0, AW'($urandom_range(0, 15)));
        step(0, 0, 0, '0, '0, 0, '0);
        step(0, 0, 0, '0, '0, 0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
